// File: rtl/alu_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_if
// Description : ALU-to-writeback handshake bundle (upstream op + RF write port)
// Revision    : 1.0
// ============================================================================
interface alu_wb_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [3:0]        in_flags;
    logic [2:0]        in_op;
    logic              in_b_zero;
    logic [RD_W-1:0]   in_rd;
    logic              in_we;
    logic              in_setf;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_we;

    modport master (
        output in_valid, in_result, in_flags, in_op, in_b_zero, in_rd, in_we, in_setf, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd, wb_we
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_op, in_b_zero, in_rd, in_we, in_setf, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd, wb_we
    );
endinterface
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_stage
// Description : Execute-to-writeback stage with 2-entry skid buffer, flag
//               commit, sticky divide-by-zero fault and retire counter
// Revision    : 1.0
// ============================================================================
module alu_wb_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_wb_if.slave               bus,
    output logic [3:0]            flags_q,
    output logic                  div0_fault,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic              r_in_ready;

    logic [DATA_W-1:0] r_m_result;
    logic [3:0]        r_m_flags;
    logic [RD_W-1:0]   r_m_rd;
    logic              r_m_we;
    logic              r_m_setf;
    logic              r_m_fault;

    logic [DATA_W-1:0] r_s_result;
    logic [3:0]        r_s_flags;
    logic [RD_W-1:0]   r_s_rd;
    logic              r_s_we;
    logic              r_s_setf;
    logic              r_s_fault;

    logic [3:0]        r_flags_q;
    logic              r_div0_fault;
    logic [CNT_W-1:0]  r_retired_cnt;

    logic              w_wb_valid;
    logic              w_accept;
    logic              w_retire;
    logic              w_fault;

    assign w_wb_valid = (r_state != c_ST_EMPTY);
    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_retire   = w_wb_valid & bus.wb_ready;
    // Divide (3) and modulo (7) by zero are the only faulting ops
    assign w_fault    = bus.in_b_zero & ((bus.in_op == 3'd3) | (bus.in_op == 3'd7));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_EMPTY;
            r_in_ready    <= 1'b1;
            r_m_result    <= '0;
            r_m_flags     <= '0;
            r_m_rd        <= '0;
            r_m_we        <= 1'b0;
            r_m_setf      <= 1'b0;
            r_m_fault     <= 1'b0;
            r_s_result    <= '0;
            r_s_flags     <= '0;
            r_s_rd        <= '0;
            r_s_we        <= 1'b0;
            r_s_setf      <= 1'b0;
            r_s_fault     <= 1'b0;
            r_flags_q     <= 4'b0000;
            r_div0_fault  <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + 1'b1;
                if (r_m_setf)  r_flags_q    <= r_m_flags;
                if (r_m_fault) r_div0_fault <= 1'b1;
            end

            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_m_result <= bus.in_result;
                        r_m_flags  <= bus.in_flags;
                        r_m_rd     <= bus.in_rd;
                        r_m_we     <= bus.in_we;
                        r_m_setf   <= bus.in_setf;
                        r_m_fault  <= w_fault;
                        r_state    <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && !w_retire) begin
                        r_s_result <= bus.in_result;
                        r_s_flags  <= bus.in_flags;
                        r_s_rd     <= bus.in_rd;
                        r_s_we     <= bus.in_we;
                        r_s_setf   <= bus.in_setf;
                        r_s_fault  <= w_fault;
                        r_state    <= c_ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_accept && w_retire) begin
                        // Old main retires this edge, new op takes its place
                        r_m_result <= bus.in_result;
                        r_m_flags  <= bus.in_flags;
                        r_m_rd     <= bus.in_rd;
                        r_m_we     <= bus.in_we;
                        r_m_setf   <= bus.in_setf;
                        r_m_fault  <= w_fault;
                    end else if (w_retire) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_TWO: begin
                    if (w_retire) begin
                        r_m_result <= r_s_result;
                        r_m_flags  <= r_s_flags;
                        r_m_rd     <= r_s_rd;
                        r_m_we     <= r_s_we;
                        r_m_setf   <= r_s_setf;
                        r_m_fault  <= r_s_fault;
                        r_state    <= c_ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wb_valid = w_wb_valid;
    assign bus.wb_data  = r_m_result;
    assign bus.wb_rd    = r_m_rd;
    assign bus.wb_we    = w_wb_valid & r_m_we & ~r_m_fault;
    assign flags_q      = r_flags_q;
    assign div0_fault   = r_div0_fault;
    assign retired_cnt  = r_retired_cnt;

endmodule
`default_nettype wire

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the ALU.
- Captures each ALU result, its V/C/Z/S flags and destination info through a valid/ready handshake, using a 2-entry skid buffer so back-pressure never drops an operation.
- Presents ops in order to the register-file write port.
- Commits condition flags to an architectural status register at writeback, raises a sticky divide-by-zero fault for ALUOp 3 (divide) and 7 (modulo), and counts retired ops.

Parameters:
- DATA_W, 32, ALU result width.
- RD_W, 5, destination register index width.
- CNT_W, 16, retired-operation counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. Synchronous, active-high.
- in_valid  input  1  upstream ALU op valid.
- in_ready  output  1  stage can accept an op this cycle.
- in_result  input  DATA_W  ALU result.
- in_flags  input  4  {V,C,Z,S} from ALU.
- in_op  input  3  ALUOp of this op.
- in_b_zero  input  1  operand b was zero.
- in_rd  input  RD_W  destination register.
- in_we  input  1  op writes the register file.
- in_setf  input  1  op updates the status register.
- wb_valid  output  1  writeback entry valid.
- wb_ready  input  1  register file accepts the entry.
- wb_data  output  DATA_W  result to write.
- wb_rd  output  RD_W  destination register.
- wb_we  output  1  write enable; wb_valid & entry we.
- flags_q  output  4  committed {V,C,Z,S}.
- div0_fault  output  1  sticky divide/modulo-by-zero fault.
- retired_cnt  output  CNT_W  count of ops written back.

Behaviour:
- Accept = in_valid & in_ready. Retire = wb_valid & wb_ready.
- Storage: main entry (drives wb_*) plus skid entry. Each entry holds result, flags, rd, we, setf and fault bit.
- Fault bit = in_b_zero & (in_op==3 | in_op==7), computed at accept.
- Occupancy states:
  - EMPTY: accept -> ONE. Entry goes to main; wb_valid=1 next cycle, so latency is 1 cycle.
  - ONE: accept & !retire -> TWO (new op to skid). Accept & retire -> ONE (new op replaces main). Retire only -> EMPTY.
  - TWO: in_ready=0. Retire -> ONE, with skid moved to main the same edge.
- Transitions not listed above leave the state unchanged.
- in_ready is a register equal to (state != TWO). It has no combinational path from wb_ready.
- wb_valid is high in ONE and TWO. wb_* come straight from main registers.
- Order is strictly FIFO; the skid entry never retires before main.
- On retire of an entry with setf=1, flags_q <= entry flags; otherwise flags_q is held.
- A faulting entry still retires normally, but:
  - wb_we is forced 0 for it;
  - div0_fault is set and stays high until rst;
  - flags are still committed if setf=1.
- retired_cnt increments by 1 on every retire, including faulted and we=0 ops. It wraps from all-ones to 0.
- Simultaneous accept and retire in ONE: the old main retires and the new op is loaded in the same cycle.
- Reset, applied at any time including mid-stream:
  - state=EMPTY, in_ready=1, wb_valid=0, wb_we=0;
  - wb_data=0, wb_rd=0, flags_q=4'b0000, div0_fault=0, retired_cnt=0;
  - buffered entries are discarded.
  - Reset has priority over accept and retire in the same cycle.
- in_* are sampled only on accept; values while in_valid=0 are ignored.

Test Plan:
- Single op: after reset, accept result=0x0000_0005, flags=0000, rd=3, we=1, setf=1 with wb_ready=1. Required: next cycle wb_valid=1, wb_data=5, wb_rd=3, wb_we=1. After retire: flags_q=0000, retired_cnt=1, state EMPTY.
- Back-pressure: hold wb_ready=0 and accept ops A (0x11) and B (0x22). Required: in_ready=0 after the second accept; a third op is not taken. Raise wb_ready: A then B retire on consecutive cycles, in_ready returns to 1, retired_cnt=2.
- Streaming: in_valid=1 and wb_ready=1 for 8 cycles with results 1..8. Required: one retire per cycle in order 1..8, state stays ONE, no bubbles after the first.
- Flags: op1 setf=1 flags=1010, op2 setf=0 flags=0101. Required: flags_q=1010 after op1 retires and remains 1010 after op2 retires.
- Divide by zero: in_op=3, in_b_zero=1, we=1, setf=1, flags=0010. Required: wb_valid=1 with wb_we=0, div0_fault=1 and sticky, flags_q=0010. A later in_op=0 op with in_b_zero=1 does not fault.
- Reset mid-operation: in state TWO, assert rst with wb_ready=1 and in_valid=1. Required: next cycle wb_valid=0, in_ready=1, flags_q=0, div0_fault=0, retired_cnt=0. Nothing is retired or accepted in the reset cycle.
